// File: rtl/seven_seg_scan.sv
// seven_seg_scan
// Time-multiplexed six-digit seven-segment driver for a common-anode display.
// Consumes the BCD digits h1 h2 : m1 m2 : s1 s2 from the time-keeping
// counters, snapshots them once per frame so a scan never tears, and scans
// the six digits one at a time, each held for SCAN_DIV clock cycles.
//
// All display outputs are registered and follow the scan state by one
// cycle, so anode, segment and decimal-point changes never skew.
//
// Optional build macro:
//   SEVEN_SEG_LZ_BLANK_EN - blank the hours-tens digit (idx 5) when the
//                           snapshotted h1 is zero (leading-zero blanking).

module seven_seg_scan #(
    parameter int SCAN_DIV = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] s1,
    input  logic [3:0] s2,
    input  logic [3:0] m1,
    input  logic [3:0] m2,
    input  logic [3:0] h1,
    input  logic [3:0] h2,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an,
    output logic       frame_done
);

    // ------------------------------------------------------------------
    // Local types and constants
    // ------------------------------------------------------------------
    localparam int               DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [2:0]       IDX_LAST = 3'd5;

    // Blank display levels (everything active-low, so all ones is dark).
    localparam logic [5:0] AN_OFF  = 6'h3F;
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'h3F;

    // One frame worth of digits, ordered as the time reads left to right.
    typedef struct packed {
        logic [3:0] h1;
        logic [3:0] h2;
        logic [3:0] m1;
        logic [3:0] m2;
        logic [3:0] s1;
        logic [3:0] s2;
    } digits_t;

    // ------------------------------------------------------------------
    // Decode helpers
    // ------------------------------------------------------------------

    // BCD nibble to active-low {g,f,e,d,c,b,a}; non-decimal codes show a dash
    // so a corrupted counter is visible rather than silently wrong.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'd0:    pat = 7'h40;
            4'd1:    pat = 7'h79;
            4'd2:    pat = 7'h24;
            4'd3:    pat = 7'h30;
            4'd4:    pat = 7'h19;
            4'd5:    pat = 7'h12;
            4'd6:    pat = 7'h02;
            4'd7:    pat = 7'h78;
            4'd8:    pat = 7'h00;
            4'd9:    pat = 7'h10;
            default: pat = SEG_DASH;
        endcase
        return pat;
    endfunction

    // Digit index to active-low anode select; out-of-range indices stay dark.
    function automatic logic [5:0] idx_to_an(input logic [2:0] i);
        logic [5:0] sel;
        case (i)
            3'd0:    sel = 6'h3E;
            3'd1:    sel = 6'h3D;
            3'd2:    sel = 6'h3B;
            3'd3:    sel = 6'h37;
            3'd4:    sel = 6'h2F;
            3'd5:    sel = 6'h1F;
            default: sel = AN_OFF;
        endcase
        return sel;
    endfunction

    // ------------------------------------------------------------------
    // Scan state
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div;
    logic [2:0]       idx;
    digits_t          shadow;
    logic             snap_q;     // a snapshot was taken on the last edge

    logic             tick;
    logic             boundary;

    // The divider only advances while enabled, so a tick cannot occur with
    // en low and the whole scan freezes in place.
    assign tick     = en && (div == DIV_LAST);
    assign boundary = tick && (idx == IDX_LAST);

    // Divider: counts 0..SCAN_DIV-1 while enabled, holds otherwise.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div <= '0;
        end else if (en) begin
            if (tick) begin
                div <= '0;
            end else begin
                div <= div + DIV_ONE;
            end
        end
    end

    // Digit index: advances on every tick, wrapping 5 -> 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx <= '0;
        end else if (tick) begin
            if (idx == IDX_LAST) begin
                idx <= '0;
            end else begin
                idx <= idx + 3'd1;
            end
        end
    end

    // Shadow register: captures the live digits only at a frame boundary.
    // NOTE: the shadow is reset (unlike a RAM) because the first frame after
    // reset must show a defined all-zeros time, not whatever powered up.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow <= '0;
            snap_q <= 1'b0;
        end else begin
            snap_q <= boundary;
            if (boundary) begin
                shadow <= '{h1: h1, h2: h2, m1: m1, m2: m2, s1: s1, s2: s2};
            end
        end
    end

    // ------------------------------------------------------------------
    // Output decode (next values for the output registers)
    // ------------------------------------------------------------------
    logic [3:0] cur_digit;
    logic [5:0] an_nxt;
    logic [6:0] seg_nxt;
    logic       dp_nxt;
    logic       frame_done_nxt;

    // Pick the shadowed digit for the current index; idx 0 is the rightmost
    // digit (seconds ones) and idx 5 the leftmost (hours tens).
    // NOTE: every signal written here gets a default first, so no path
    // through the block can leave a value unassigned and infer a latch.
    always_comb begin
        cur_digit = shadow.s2;
        case (idx)
            3'd0:    cur_digit = shadow.s2;
            3'd1:    cur_digit = shadow.s1;
            3'd2:    cur_digit = shadow.m2;
            3'd3:    cur_digit = shadow.m1;
            3'd4:    cur_digit = shadow.h2;
            3'd5:    cur_digit = shadow.h1;
            default: cur_digit = shadow.s2;
        endcase
    end

    // Build the next display word; blank everything when scanning is off.
    always_comb begin
        an_nxt         = AN_OFF;
        seg_nxt        = SEG_OFF;
        dp_nxt         = 1'b1;
        frame_done_nxt = 1'b0;
        if (en) begin
            an_nxt         = idx_to_an(idx);
            seg_nxt        = bcd_to_seg(cur_digit);
            // Points after the hours and minutes pairs read as hh.mm.ss.
            dp_nxt         = !((idx == 3'd2) || (idx == 3'd4));
            // Pulse lines up with the first digit drawn from the new snapshot.
            frame_done_nxt = snap_q;
`ifdef SEVEN_SEG_LZ_BLANK_EN
            // Leading-zero hour: keep the anode on, light no segments.
            if ((idx == IDX_LAST) && (shadow.h1 == 4'd0)) begin
                seg_nxt = SEG_OFF;
            end
`endif
        end
    end

    // Output registers: glitch-free pins, all updated on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            an         <= an_nxt;
            seg        <= seg_nxt;
            dp         <= dp_nxt;
            frame_done <= frame_done_nxt;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan
// Directed, scoreboard-driven bench for seven_seg_scan with SCAN_DIV = 4.
// Expected display words are queued when the stimulus is set up and are
// popped and compared on falling edges as the DUT produces them.
// Honours SEVEN_SEG_LZ_BLANK_EN when computing expected segments.

module tb_seven_seg_scan;

    localparam int DIV = 4;

    logic       clk;
    logic       reset;
    logic       en;
    logic [3:0] s1, s2, m1, m2, h1, h2;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;
    logic       frame_done;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [5:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    exp_t sb[$];

    seven_seg_scan #(.SCAN_DIV(DIV)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .s1         (s1),
        .s2         (s2),
        .m1         (m1),
        .m2         (m2),
        .h1         (h1),
        .h2         (h2),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [6:0] seg_pat(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    function automatic logic [5:0] an_of(input int i);
        case (i)
            0: return 6'h3E;
            1: return 6'h3D;
            2: return 6'h3B;
            3: return 6'h37;
            4: return 6'h2F;
            default: return 6'h1F;
        endcase
    endfunction

    // d is {h1,h2,m1,m2,s1,s2}; idx 0 is s2 (lowest nibble).
    function automatic logic [6:0] seg_of(input logic [23:0] d, input int i);
        logic [3:0] nib;
        nib = d[4*i +: 4];
`ifdef SEVEN_SEG_LZ_BLANK_EN
        if (i == 5 && nib == 4'd0) return 7'h7F;
`endif
        return seg_pat(nib);
    endfunction

    // Queue frame entries k_lo..k_hi (1..24); entry k shows idx (k-1)/DIV.
    task automatic push_entries(input logic [23:0] d, input bit first_fd,
                                input int k_lo, input int k_hi);
        exp_t e;
        for (int k = k_lo; k <= k_hi; k++) begin
            int i;
            i = (k - 1) / DIV;
            e.an  = an_of(i);
            e.seg = seg_of(d, i);
            e.dp  = (i == 2 || i == 4) ? 1'b0 : 1'b1;
            e.fd  = first_fd && (k == 1);
            sb.push_back(e);
        end
    endtask

    task automatic push_blank(input int n);
        exp_t e;
        e.an = 6'h3F; e.seg = 7'h7F; e.dp = 1'b1; e.fd = 1'b0;
        repeat (n) sb.push_back(e);
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] expv);
        n_assert++;
        assert (got === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, expv);
        end
    endtask

    task automatic chk_blank(input string tag);
        chk({tag, ".an"},  {2'b00, an},  8'h3F);
        chk({tag, ".seg"}, {1'b0, seg},  8'h7F);
        chk({tag, ".dp"},  {7'd0, dp},   8'h01);
        chk({tag, ".fd"},  {7'd0, frame_done}, 8'h00);
    endtask

    // Pop and compare one queued word per falling edge for n cycles.
    task automatic check_cycles(input int n, input string tag);
        exp_t e;
        repeat (n) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                n_assert++;
                n_fail++;
                $error("FAIL %s: observed empty scoreboard expected queued word", tag);
            end else begin
                e = sb.pop_front();
                chk({tag, ".an"},  {2'b00, an},  {2'b00, e.an});
                chk({tag, ".seg"}, {1'b0, seg},  {1'b0, e.seg});
                chk({tag, ".dp"},  {7'd0, dp},   {7'd0, e.dp});
                chk({tag, ".fd"},  {7'd0, frame_done}, {7'd0, e.fd});
            end
        end
    endtask

    task automatic set_time(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d,
                            input logic [3:0] e, input logic [3:0] f);
        h1 = a; h2 = b; m1 = c; m2 = d; s1 = e; s2 = f;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0;
        en    = 1'b1;
        set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);

        // Reset state.
        repeat (2) @(negedge clk);
        chk_blank("reset");
        reset = 1'b1;

        // First frame: zeros from the reset shadow; second frame: 12:34:56.
        push_entries(24'h000000, 1'b0, 1, 24);
        push_entries(24'h123456, 1'b1, 1, 24);
        check_cycles(24, "frame_zero");

        // Mid-frame input change must not disturb the frame in progress.
        check_cycles(8, "frame_1a");
        set_time(4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd9);
        check_cycles(16, "frame_1b");

        // New value after frame_done; invalid s2 injected mid-frame.
        push_entries(24'h235959, 1'b1, 1, 24);
        check_cycles(8, "frame_2a");
        s2 = 4'hC;
        check_cycles(16, "frame_2b");

        // Enable gating at idx=3, div=2: blank 10 cycles, then resume.
        push_entries(24'h23595C, 1'b1, 1, 14);
        push_blank(10);
        push_entries(24'h23595C, 1'b0, 15, 24);
        check_cycles(14, "gate_pre");
        en = 1'b0;
        check_cycles(10, "gate_off");
        en = 1'b1;
        check_cycles(10, "gate_post");

        // Asynchronous reset at idx=4, between clock edges.
        push_entries(24'h23595C, 1'b1, 1, 18);
        check_cycles(18, "pre_areset");
        #2 reset = 1'b0;
        #1 chk_blank("areset_now");
        sb.delete();
        set_time(4'd0, 4'd9, 4'd5, 4'd9, 4'd5, 4'hC);
        repeat (2) @(negedge clk);
        chk_blank("areset_hold");
        reset = 1'b1;

        // Restart from idx 0 with zeros, then the leading-zero hour frame.
        push_entries(24'h000000, 1'b0, 1, 24);
        push_entries(24'h09595C, 1'b1, 1, 24);
        check_cycles(24, "restart_zero");
        check_cycles(24, "lz_frame");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
